// File: rtl/pool_wb_desc_gen.sv
// Pooling write-back descriptor generator: walks groups x padded vectors and pushes
// one {addr, mask, last} descriptor per gathered vector. Optional POOL_WB_DESC_GEN_PERF_EN adds stall_cnt.
module pool_wb_desc_gen #(
    parameter int RTM_DEPTH = 1024,
    parameter int CNT_W     = 16,
    localparam int AW       = $clog2(RTM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic [AW-1:0]    cfg_base_addr,
    input  logic [AW-1:0]    cfg_grp_stride,
    input  logic [CNT_W-1:0] cfg_n_grps,
    input  logic [CNT_W-1:0] cfg_n_vecs,
    input  logic [CNT_W-1:0] cfg_n_vecs_pad,
    input  logic             desc_fifo_almost_full,
    output logic             desc_fifo_wr_en,
    output logic [AW-1:0]    desc_fifo_din_addr,
    output logic             desc_fifo_din_mask,
    output logic             desc_fifo_din_last,
    output logic             busy,
    output logic             done_pulse
`ifdef POOL_WB_DESC_GEN_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_n;

    logic [AW-1:0]    stride_r;
    logic [CNT_W-1:0] n_grps_r;
    logic [CNT_W-1:0] n_vecs_r;
    logic [CNT_W-1:0] n_vecs_pad_r;
    logic [CNT_W-1:0] g_r;
    logic [CNT_W-1:0] v_r;
    logic [AW-1:0]    grp_addr_r;

    logic [AW-1:0]    stride_n;
    logic [CNT_W-1:0] n_grps_n;
    logic [CNT_W-1:0] n_vecs_n;
    logic [CNT_W-1:0] n_vecs_pad_n;
    logic [CNT_W-1:0] g_n;
    logic [CNT_W-1:0] v_n;
    logic [AW-1:0]    grp_addr_n;

    logic             wr_en_r;
    logic [AW-1:0]    addr_r;
    logic             mask_r;
    logic             last_r;
    logic             busy_r;
    logic             done_r;

    logic             wr_en_n;
    logic [AW-1:0]    addr_n;
    logic             mask_n;
    logic             last_n;
    logic             busy_n;
    logic             done_n;

    logic             start_ok_s;
    logic             cfg_bad_s;
    logic             push_s;
    logic             end_grp_s;
    logic             is_last_s;

    assign start_ok_s = (state_r == IDLE) && start_pulse;
    assign cfg_bad_s  = (cfg_n_grps == {CNT_W{1'b0}}) || (cfg_n_vecs_pad == {CNT_W{1'b0}}) ||
                        (cfg_n_vecs > cfg_n_vecs_pad);
    assign push_s     = (state_r == RUN) && !desc_fifo_almost_full;
    assign end_grp_s  = (v_r == (n_vecs_pad_r - CNT_W'(1)));
    assign is_last_s  = end_grp_s && (g_r == (n_grps_r - CNT_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (start_pulse) begin
                    state_n = cfg_bad_s ? FIN : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (push_s && is_last_s) begin
                    state_n = FIN;
                end else begin
                    state_n = RUN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output decode: next values of the registered FIFO and status outputs
    always_comb begin
        wr_en_n = 1'b0;
        addr_n  = {AW{1'b0}};
        mask_n  = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state_r)
            IDLE: begin
                busy_n = start_pulse;
            end
            RUN: begin
                busy_n = 1'b1;
                if (push_s) begin
                    wr_en_n = 1'b1;
                    addr_n  = grp_addr_r + AW'(v_r);
                    mask_n  = (v_r >= n_vecs_r);
                    last_n  = is_last_s;
                end else begin
                    wr_en_n = 1'b0;
                end
            end
            FIN: begin
                done_n = 1'b1;
                busy_n = 1'b0;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // Config latch and group/vector walk
    always_comb begin
        stride_n     = stride_r;
        n_grps_n     = n_grps_r;
        n_vecs_n     = n_vecs_r;
        n_vecs_pad_n = n_vecs_pad_r;
        g_n          = g_r;
        v_n          = v_r;
        grp_addr_n   = grp_addr_r;
        if (start_ok_s) begin
            stride_n     = cfg_grp_stride;
            n_grps_n     = cfg_n_grps;
            n_vecs_n     = cfg_n_vecs;
            n_vecs_pad_n = cfg_n_vecs_pad;
            g_n          = {CNT_W{1'b0}};
            v_n          = {CNT_W{1'b0}};
            grp_addr_n   = cfg_base_addr;
        end else if (push_s) begin
            if (end_grp_s) begin
                v_n        = {CNT_W{1'b0}};
                g_n        = g_r + CNT_W'(1);
                grp_addr_n = grp_addr_r + stride_r;
            end else begin
                v_n = v_r + CNT_W'(1);
            end
        end else begin
            g_n = g_r;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_r     <= {AW{1'b0}};
            n_grps_r     <= {CNT_W{1'b0}};
            n_vecs_r     <= {CNT_W{1'b0}};
            n_vecs_pad_r <= {CNT_W{1'b0}};
            g_r          <= {CNT_W{1'b0}};
            v_r          <= {CNT_W{1'b0}};
            grp_addr_r   <= {AW{1'b0}};
            wr_en_r      <= 1'b0;
            addr_r       <= {AW{1'b0}};
            mask_r       <= 1'b0;
            last_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            stride_r     <= stride_n;
            n_grps_r     <= n_grps_n;
            n_vecs_r     <= n_vecs_n;
            n_vecs_pad_r <= n_vecs_pad_n;
            g_r          <= g_n;
            v_r          <= v_n;
            grp_addr_r   <= grp_addr_n;
            wr_en_r      <= wr_en_n;
            addr_r       <= addr_n;
            mask_r       <= mask_n;
            last_r       <= last_n;
            busy_r       <= busy_n;
            done_r       <= done_n;
        end
    end

    assign desc_fifo_wr_en    = wr_en_r;
    assign desc_fifo_din_addr = addr_r;
    assign desc_fifo_din_mask = mask_r;
    assign desc_fifo_din_last = last_r;
    assign busy               = busy_r;
    assign done_pulse         = done_r;

`ifdef POOL_WB_DESC_GEN_PERF_EN
    logic [31:0] stall_cnt_r;

    // Back-pressure cycle counter, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (start_ok_s) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r == RUN) && desc_fifo_almost_full && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    // Performance counter not built.
`endif

endmodule

// File: tb/tb_pool_wb_desc_gen.sv
// Randomized self-checking bench for pool_wb_desc_gen against a loop-nest descriptor model.
module tb_pool_wb_desc_gen;
    localparam int RTM_DEPTH = 1024;
    localparam int CNT_W     = 16;
    localparam int AW        = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_pulse;
    logic [AW-1:0]    cfg_base_addr;
    logic [AW-1:0]    cfg_grp_stride;
    logic [CNT_W-1:0] cfg_n_grps;
    logic [CNT_W-1:0] cfg_n_vecs;
    logic [CNT_W-1:0] cfg_n_vecs_pad;
    logic             af;
    logic             wr_en;
    logic [AW-1:0]    addr;
    logic             mask;
    logic             last;
    logic             busy;
    logic             done;
`ifdef POOL_WB_DESC_GEN_PERF_EN
    logic [31:0]      stall_cnt;
`endif

    pool_wb_desc_gen #(.RTM_DEPTH(RTM_DEPTH), .CNT_W(CNT_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_pulse           (start_pulse),
        .cfg_base_addr         (cfg_base_addr),
        .cfg_grp_stride        (cfg_grp_stride),
        .cfg_n_grps            (cfg_n_grps),
        .cfg_n_vecs            (cfg_n_vecs),
        .cfg_n_vecs_pad        (cfg_n_vecs_pad),
        .desc_fifo_almost_full (af),
        .desc_fifo_wr_en       (wr_en),
        .desc_fifo_din_addr    (addr),
        .desc_fifo_din_mask    (mask),
        .desc_fifo_din_last    (last),
        .busy                  (busy),
        .done_pulse            (done)
`ifdef POOL_WB_DESC_GEN_PERF_EN
        ,
        .stall_cnt             (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        mask;
        logic        last;
    } desc_t;

    desc_t got_q[$];
    desc_t exp_q[$];
    int    cyc = 0;
    int    first_wr_cyc, last_wr_cyc, done_cyc, done_cnt, busy_cnt;
    int    errs = 0;
    int    checks = 0;

    // Free-running cycle index
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) begin
            if (got_q.size() == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            got_q.push_back('{32'(addr), mask, last});
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain loop nest over groups and padded vectors
    task automatic build_exp(input int base, input int stride, input int ng, input int nv, input int nvp);
        exp_q.delete();
        if (ng == 0 || nvp == 0 || nv > nvp) return;
        for (int g = 0; g < ng; g++)
            for (int v = 0; v < nvp; v++)
                exp_q.push_back('{32'((base + g * stride + v) % RTM_DEPTH), (v >= nv),
                                  (g == ng - 1 && v == nvp - 1)});
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        first_wr_cyc = -1;
        last_wr_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic cmp_descs(input string name, input int n);
        for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++) begin
            check_val($sformatf("%s:addr%0d", name, i), got_q[i].addr, exp_q[i].addr);
            check_val($sformatf("%s:mask%0d", name, i), 32'(got_q[i].mask), 32'(exp_q[i].mask));
            check_val($sformatf("%s:last%0d", name, i), 32'(got_q[i].last), 32'(exp_q[i].last));
        end
    endtask

    task automatic drive_start(input int base, input int stride, input int ng, input int nv, input int nvp);
        start_pulse    = 1'b1;
        cfg_base_addr  = AW'(base);
        cfg_grp_stride = AW'(stride);
        cfg_n_grps     = CNT_W'(ng);
        cfg_n_vecs     = CNT_W'(nv);
        cfg_n_vecs_pad = CNT_W'(nvp);
    endtask

    // mode 0: no stall, 1: random almost_full, 2: 5-cycle stall after 2nd push, 3: start while busy
    task automatic run_job(input string name, input int base, input int stride, input int ng,
                           input int nv, input int nvp, input int mode);
        int start_cyc, seen, stall_left, budget;
        bit stalled;
        build_exp(base, stride, ng, nv, nvp);
        clear_mon();
        @(posedge clk); #1;
        start_cyc = cyc;
        af = 1'b0;
        drive_start(base, stride, ng, nv, nvp);
        seen = 0; stall_left = 0; stalled = 1'b0;
        budget = ng * nvp * 4 + 40;
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            start_pulse = 1'b0;
            if (wr_en) seen++;
            if (mode == 1) begin
                af = ($urandom_range(0, 3) == 0);
            end else if (mode == 2) begin
                if (seen == 2 && !stalled) begin
                    stall_left = 5;
                    stalled = 1'b1;
                end
                af = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end else if (mode == 3 && seen == 1) begin
                drive_start((base + 'h155) % RTM_DEPTH, stride + 1, ng + 1, nv, nvp);
            end else begin
                af = 1'b0;
            end
        end
        af = 1'b0;
        start_pulse = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_val({name, ":done_cnt"}, done_cnt, 1);
        check_val({name, ":n_push"}, got_q.size(), exp_q.size());
        cmp_descs(name, exp_q.size());
        if (exp_q.size() == 0)
            check_val({name, ":done_at"}, done_cyc, start_cyc + 2);
        else
            check_val({name, ":done_at"}, done_cyc, last_wr_cyc + 1);
        if (mode != 1 && exp_q.size() != 0)
            check_val({name, ":latency"}, first_wr_cyc, start_cyc + 2);
        check_val({name, ":busy_len"}, busy_cnt, done_cyc - start_cyc - 1);
`ifdef POOL_WB_DESC_GEN_PERF_EN
        if (mode == 2) check_val({name, ":stall_cnt"}, stall_cnt, 5);
        if (mode == 0) check_val({name, ":stall_cnt"}, stall_cnt, 0);
`endif
    endtask

    task automatic run_reset_mid();
        int seen;
        build_exp(16'h20, 16'h30, 4, 5, 8);
        clear_mon();
        @(posedge clk); #1;
        af = 1'b0;
        drive_start(16'h20, 16'h30, 4, 5, 8);
        seen = 0;
        for (int c = 0; c < 60 && seen < 10; c++) begin
            @(posedge clk); #1;
            start_pulse = 1'b0;
            if (wr_en) seen++;
        end
        check_val("rst_mid:seen", seen, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid:wr_en", 32'(wr_en), 0);
        check_val("rst_mid:busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_mid:n_push", got_q.size(), 10);
        check_val("rst_mid:done", done_cnt, 0);
        cmp_descs("rst_mid", 10);
    endtask

    initial begin
        int ng, nvp, nv;
        rst = 1'b1;
        start_pulse = 1'b0;
        af = 1'b0;
        cfg_base_addr = '0;
        cfg_grp_stride = '0;
        cfg_n_grps = '0;
        cfg_n_vecs = '0;
        cfg_n_vecs_pad = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset:wr_en", 32'(wr_en), 0);
        check_val("reset:busy", 32'(busy), 0);
        check_val("reset:done", 32'(done), 0);
        check_val("reset:addr", 32'(addr), 0);
`ifdef POOL_WB_DESC_GEN_PERF_EN
        check_val("reset:stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;

        run_job("single", 'h10, 'h40, 1, 3, 4, 0);
        run_job("wrap", 'h3FE, 'h100, 2, 3, 3, 0);
        run_job("backpressure", 'h10, 'h40, 1, 3, 4, 2);
        run_job("zero_grps", 'h55, 'h10, 0, 3, 4, 0);
        run_job("zero_pad", 'h55, 'h10, 2, 0, 0, 0);
        run_job("illegal", 'h55, 'h10, 2, 5, 4, 0);
        run_reset_mid();
        run_job("rst_replay", 'h20, 'h30, 4, 5, 8, 0);
        run_job("busy_start", 'h80, 'h20, 2, 4, 5, 3);

        for (int j = 0; j < 25; j++) begin
            ng  = $urandom_range(0, 3);
            nvp = $urandom_range(0, 6);
            nv  = $urandom_range(0, nvp + 1);
            run_job($sformatf("rand%0d", j), $urandom_range(0, RTM_DEPTH - 1),
                    $urandom_range(0, RTM_DEPTH - 1), ng, nv, nvp, 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
